sound_i2s_out: RTL and testbench

//  Output stage downstream of the sound mixer. Takes the mixed signed 16-bit

---
 rtl/sound_i2s_out.sv | 99 +++++++++
 tb/tb_sound_i2s_out.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_i2s_out.sv
// I2S serialiser for the mixed stereo stream: fractional-rate BCLK generation,
// 64-bit frames with the master attenuation/mute applied once per frame latch.
module sound_i2s_out #(
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] clock_rate,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic [3:0]  atten,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        sample_tick
);

  // Two BCLK edges per bit, 64 bits per frame: 128 edges per output sample.
  localparam logic [28:0] ACC_INC = 29'(128 * SAMPLE_RATE);

  logic [27:0] clk_rate;
  logic [27:0] acc;
  logic [28:0] acc_sum;
  logic        toggle;
  logic        fall;

  logic [5:0]  bit_cnt;
  logic [5:0]  bit_cnt_nxt;
  logic [4:0]  slot_pos;
  logic [15:0] slot_word;
  logic [3:0]  bit_sel;
  logic        data_nxt;

  logic [15:0] left;
  logic [15:0] right;
  logic [15:0] left_nxt;
  logic [15:0] right_nxt;

  // One extra bit keeps sum+increment from wrapping near the 28-bit ceiling.
  always_comb begin
    acc_sum = {1'b0, acc} + ACC_INC;
    toggle  = (clk_rate != '0) && (acc_sum >= {1'b0, clk_rate});
    fall    = toggle && i2s_bclk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_rate <= '0;
      acc      <= '0;
    end else begin
      clk_rate <= clock_rate;
      if (clk_rate != '0) begin
        if (toggle) acc <= 28'(acc_sum - {1'b0, clk_rate});
        else        acc <= acc_sum[27:0];
      end
    end
  end

  always_comb begin
    bit_cnt_nxt = bit_cnt + 6'd1;
    slot_pos    = bit_cnt_nxt[4:0];
    slot_word   = bit_cnt_nxt[5] ? right : left;
    bit_sel     = 4'(5'd16 - slot_pos);
    data_nxt    = ((slot_pos >= 5'd1) && (slot_pos <= 5'd16)) ? slot_word[bit_sel] : 1'b0;
  end

  always_comb begin
    left_nxt  = mute ? 16'h0000 : 16'($signed(sample_l) >>> atten);
    right_nxt = mute ? 16'h0000 : 16'($signed(sample_r) >>> atten);
  end

  // Everything frame-related moves on the falling BCLK edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_data    <= 1'b0;
      sample_tick <= 1'b0;
      bit_cnt     <= 6'd63;
      left        <= '0;
      right       <= '0;
    end else begin
      sample_tick <= 1'b0;
      if (toggle) i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_cnt   <= bit_cnt_nxt;
        i2s_lrclk <= bit_cnt_nxt[5];
        i2s_data  <= data_nxt;
        if (bit_cnt_nxt == 6'd0) begin
          left        <= left_nxt;
          right       <= right_nxt;
          sample_tick <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_i2s_out.sv
// Bench for sound_i2s_out: frame latches push expected words, a rising-BCLK
// decoder rebuilds each frame and scores it; timing checks run inline.
`timescale 1ns/1ps
module tb_sound_i2s_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] clock_rate;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic [3:0]  atten;
  logic        mute;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        sample_tick;

  int checks = 0;
  int errors = 0;
  int frames_done = 0;

  logic [15:0] exp_l;
  logic [15:0] exp_r;
  logic [31:0] exp_q[$];

  logic [63:0] dbits;
  logic [63:0] lbits;
  int          bit_idx = 0;
  bit          dec_on = 1'b0;
  logic        bclk_prev = 1'b0;

  sound_i2s_out #(.SAMPLE_RATE(48000)) dut (
    .clk         (clk),
    .rst         (rst),
    .clock_rate  (clock_rate),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .atten       (atten),
    .mute        (mute),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_data    (i2s_data),
    .sample_tick (sample_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Each latch queues the words the stimulus says should be in that frame.
  always @(negedge clk) begin
    if (!rst && sample_tick) exp_q.push_back({exp_l, exp_r});
  end

  task automatic score_frame();
    logic [31:0] e;
    logic [15:0] gl;
    logic [15:0] gr;
    int pad_err;
    int lr_err;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: frame decoded with no expected entry");
      return;
    end
    e = exp_q.pop_front();
    pad_err = 0;
    lr_err  = 0;
    for (int k = 0; k < 16; k++) begin
      gl[15-k] = dbits[1+k];
      gr[15-k] = dbits[33+k];
    end
    for (int i = 0; i < 64; i++) begin
      if (!((i >= 1 && i <= 16) || (i >= 33 && i <= 48)) && dbits[i] !== 1'b0) pad_err++;
      if (lbits[i] !== ((i >= 32) ? 1'b1 : 1'b0)) lr_err++;
    end
    check("left_word", gl, e[31:16]);
    check("right_word", gr, e[15:0]);
    check("pad_bits", pad_err, 0);
    check("lrclk_slot", lr_err, 0);
    frames_done++;
  endtask

  // Decoder samples like the codec: data/lrclk at each rising BCLK.
  always @(negedge clk) begin
    if (rst) begin
      dec_on    = 1'b0;
      bit_idx   = 0;
      bclk_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (sample_tick) begin
        if (dec_on) begin
          check("frame_complete", bit_idx, 64);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        dec_on  = 1'b1;
        bit_idx = 0;
      end else if (dec_on && i2s_bclk && !bclk_prev) begin
        dbits[bit_idx] = i2s_data;
        lbits[bit_idx] = i2s_lrclk;
        bit_idx++;
        if (bit_idx == 64) begin
          dec_on = 1'b0;
          score_frame();
        end
      end
      bclk_prev = i2s_bclk;
    end
  end

  task automatic wait_tick(input string name, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < budget);
    if (!sample_tick) begin
      checks++;
      errors++;
      $display("FAIL %s: no sample_tick within %0d clk", name, budget);
    end
  endtask

  task automatic measure_phases(input int nph, output int mn, output int mx);
    logic prev;
    int len;
    int got;
    int guard;
    mn = 1 << 30;
    mx = 0;
    got = -1;
    len = 0;
    guard = 0;
    prev = i2s_bclk;
    while (got < nph && guard < 4000) begin
      @(negedge clk);
      guard++;
      len++;
      if (i2s_bclk !== prev) begin
        if (got >= 0) begin
          if (len < mn) mn = len;
          if (len > mx) mx = len;
        end
        got++;
        len = 0;
        prev = i2s_bclk;
      end
    end
    if (got < nph) begin
      checks++;
      errors++;
      $display("FAIL bclk_phase_timeout: only %0d phases seen", got);
    end
  endtask

  task automatic set_vec(input logic [15:0] l, input logic [15:0] r, input logic [3:0] a,
                         input logic m, input logic [15:0] el, input logic [15:0] er);
    sample_l = l;
    sample_r = r;
    atten    = a;
    mute     = m;
    exp_l    = el;
    exp_r    = er;
  endtask

  initial begin
    int n;
    int mn;
    int mx;
    int ticks;
    int changes;
    int len;
    logic prev_b;
    logic hold_b;
    logic hold_lr;
    logic hold_d;
    bit first_phase;

    rst = 1'b1;
    clock_rate = 28'd12_288_000;
    set_vec(16'hA5A5, 16'h1234, 4'd0, 1'b0, 16'hA5A5, 16'h1234);
    repeat (3) @(negedge clk);
    check("reset_bclk", i2s_bclk, 1'b0);
    check("reset_lrclk", i2s_lrclk, 1'b0);
    check("reset_data", i2s_data, 1'b0);
    check("reset_tick", sample_tick, 1'b0);
    rst = 1'b0;

    wait_tick("first_latch", 20, n);
    check_range("first_latch_delay", n, 4, 6);

    // BCLK every 2 clk at this rate: 256-clk frames, no jitter.
    wait_tick("settle_12m", 600, n);
    for (int i = 0; i < 3; i++) begin
      wait_tick("interval_12m", 600, n);
      check("tick_interval_12m", n, 256);
    end
    #1;
    measure_phases(20, mn, mx);
    check("bclk_phase_min_12m", mn, 2);
    check("bclk_phase_max_12m", mx, 2);

    wait_tick("vec_atten4", 600, n);
    #1 set_vec(16'h8000, 16'h7FF0, 4'd4, 1'b0, 16'hF800, 16'h07FF);
    wait_tick("vec_atten4", 600, n);
    wait_tick("vec_atten4", 600, n);

    #1 set_vec(16'h8001, 16'h7FFF, 4'd15, 1'b0, 16'hFFFF, 16'h0000);
    wait_tick("vec_atten15", 600, n);
    wait_tick("vec_atten15", 600, n);

    #1 set_vec(16'h0003, 16'hFFFE, 4'd1, 1'b0, 16'h0001, 16'hFFFF);
    wait_tick("vec_lsb", 600, n);
    wait_tick("vec_lsb", 600, n);

    #1 set_vec(16'h5A5A, 16'hC3C3, 4'd0, 1'b0, 16'h5A5A, 16'hC3C3);
    wait_tick("vec_mute_pre", 600, n);
    wait_tick("vec_mute_pre", 600, n);
    // Mute and a new shift arrive around bit 20; only the next latch may see them.
    repeat (82) @(negedge clk);
    #1 set_vec(16'h5A5A, 16'hC3C3, 4'd3, 1'b1, 16'h0000, 16'h0000);
    wait_tick("vec_mute", 600, n);
    wait_tick("vec_mute", 600, n);
    #1 set_vec(16'h5A5A, 16'hC3C3, 4'd3, 1'b0, 16'h0B4B, 16'hF878);
    wait_tick("vec_unmute", 600, n);
    wait_tick("vec_unmute", 600, n);

    // Half the edge rate: BCLK every 4 clk, 512-clk frames.
    #1 clock_rate = 28'd24_576_000;
    wait_tick("settle_24m", 1200, n);
    for (int i = 0; i < 2; i++) begin
      wait_tick("interval_24m", 1200, n);
      check("tick_interval_24m", n, 512);
    end
    #1;
    measure_phases(12, mn, mx);
    check("bclk_phase_min_24m", mn, 4);
    check("bclk_phase_max_24m", mx, 4);

    // Rate of zero freezes the serialiser mid-frame.
    wait_tick("pre_freeze", 1200, n);
    repeat (50) @(negedge clk);
    clock_rate = 28'd0;
    repeat (2) @(negedge clk);
    hold_b  = i2s_bclk;
    hold_lr = i2s_lrclk;
    hold_d  = i2s_data;
    ticks   = 0;
    changes = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (sample_tick) ticks++;
      if (i2s_bclk !== hold_b || i2s_lrclk !== hold_lr || i2s_data !== hold_d) changes++;
    end
    check("freeze_ticks", ticks, 0);
    check("freeze_output_changes", changes, 0);
    clock_rate = 28'd12_288_000;
    wait_tick("unfreeze", 1200, n);
    wait_tick("unfreeze", 600, n);

    // Reset mid-frame while lrclk is high, asynchronously between clk edges.
    repeat (162) @(negedge clk);
    n = 0;
    while (i2s_bclk !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_lrclk", i2s_lrclk, 1'b1);
    check("pre_reset_bclk", i2s_bclk, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_bclk", i2s_bclk, 1'b0);
    check("rst_async_lrclk", i2s_lrclk, 1'b0);
    check("rst_async_data", i2s_data, 1'b0);
    check("rst_async_tick", sample_tick, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_tick("relatch", 20, n);
    check_range("relatch_delay", n, 4, 6);

    // 50 MHz: non-integer BCLK ratio, ~1041.67 clk per frame.
    #1 clock_rate = 28'd50_000_000;
    wait_tick("settle_50m", 2500, n);
    wait_tick("settle_50m", 2500, n);
    ticks = 0;
    mn = 1 << 30;
    mx = 0;
    len = 0;
    first_phase = 1'b1;
    prev_b = i2s_bclk;
    for (int i = 0; i < 50000; i++) begin
      @(negedge clk);
      len++;
      if (sample_tick) ticks++;
      if (i2s_bclk !== prev_b) begin
        if (!first_phase) begin
          if (len < mn) mn = len;
          if (len > mx) mx = len;
        end
        first_phase = 1'b0;
        len = 0;
        prev_b = i2s_bclk;
      end
    end
    check_range("ticks_50m", ticks, 47, 49);
    check_range("bclk_phase_spread_50m", mx - mn, 0, 1);
    check_range("bclk_phase_min_50m", mn, 8, 9);
    check_range("bclk_phase_max_50m", mx, 8, 9);

    wait_tick("drain", 2500, n);
    wait_tick("drain", 2500, n);
    check_range("frames_scored", frames_done, 60, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
